// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one ALU between NREQ requesters.
// A round-robin arbiter picks one pending request and registers its
// operands onto the ALU ports. The ALU result is captured one cycle
// later and returned to the winner over a valid/ready response handshake.
// NBITS is the datapath width used throughout the ALU datapath.
module alu_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  localparam int RIDX = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_f,
  input  logic [NBITS*NREQ-1:0]   req_a,
  input  logic [NBITS*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic [1:0]              alu_f,
  output logic [NBITS-1:0]        alu_a,
  output logic [NBITS-1:0]        alu_b,
  output logic                    alu_cin,
  input  logic [NBITS-1:0]        alu_y,
  input  logic                    alu_cout,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [NBITS-1:0]        resp_y,
  output logic                    resp_cout,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [RIDX-1:0]   rr_ptr_q, rr_ptr_d;
  logic [RIDX-1:0]   gnt_q, gnt_d;
  logic [1:0]        alu_f_q, alu_f_d;
  logic [NBITS-1:0]  alu_a_q, alu_a_d;
  logic [NBITS-1:0]  alu_b_q, alu_b_d;
  logic              alu_cin_q, alu_cin_d;
  logic [NBITS-1:0]  resp_y_q, resp_y_d;
  logic              resp_cout_q, resp_cout_d;

  logic              any_valid;
  logic [RIDX-1:0]   win_idx;
  logic [RIDX-1:0]   cand;
  int                idx;

  // Round-robin search: first valid requester at or after rr_ptr_q, circularly.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    any_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = RIDX'(idx);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state, grant and datapath-load logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    alu_f_d     = alu_f_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    resp_y_d    = resp_y_q;
    resp_cout_d = resp_cout_q;
    req_ready   = '0;

    unique case (state_q)
      S_IDLE: begin
        // Reset is folded in so req_ready reads zero while rst is held,
        // even if requesters keep req_valid high.
        if (any_valid && !rst) begin
          req_ready[win_idx] = 1'b1;
          gnt_d              = win_idx;
          alu_f_d            = req_f[2*int'(win_idx) +: 2];
          alu_a_d            = req_a[NBITS*int'(win_idx) +: NBITS];
          alu_b_d            = req_b[NBITS*int'(win_idx) +: NBITS];
          alu_cin_d          = req_cin[win_idx];
          state_d            = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_y_d    = alu_y;
        resp_cout_d = alu_cout;
        state_d     = S_RESP;
      end
      S_RESP: begin
        // Only the owner's resp_ready completes the transaction.
        if (resp_ready[gnt_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointer and datapath registers; async reset discards any in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      alu_f_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      resp_y_q    <= '0;
      resp_cout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      alu_f_q     <= alu_f_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      resp_y_q    <= resp_y_d;
      resp_cout_q <= resp_cout_d;
    end
  end

  assign alu_f      = alu_f_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign resp_y     = resp_y_q;
  assign resp_cout  = resp_cout_q;
  assign resp_valid = (state_q == S_RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a carry-propagating adder as the ALU.
module tb_alu_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_f;
  logic [NBITS*NREQ-1:0] req_a;
  logic [NBITS*NREQ-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [1:0]            alu_f;
  logic [NBITS-1:0]      alu_a;
  logic [NBITS-1:0]      alu_b;
  logic                  alu_cin;
  logic [NBITS-1:0]      alu_y;
  logic                  alu_cout;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [NBITS-1:0]      resp_y;
  logic                  resp_cout;
  logic                  busy;

  int n_checks;
  int n_pass;

  alu_rr_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_f      (req_f),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .alu_f      (alu_f),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_y      (alu_y),
    .alu_cout   (alu_cout),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .resp_cout  (resp_cout),
    .busy       (busy)
  );

  // ALU stand-in: y/cout = a + b + cin.
  assign {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] f, input logic [7:0] a,
                         input logic [7:0] b, input logic cin);
    req_f[2*i +: 2]         = f;
    req_a[NBITS*i +: NBITS] = a;
    req_b[NBITS*i +: NBITS] = b;
    req_cin[i]              = cin;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    req_valid  = '0;
    req_f      = '0;
    req_a      = '0;
    req_b      = '0;
    req_cin    = '0;
    resp_ready = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_resp_y", 32'(resp_y), 32'h0);
    tick();

    // Single request from requester 2: 3C + 05 + 1 = 42, no carry.
    set_req(2, 2'b11, 8'h3C, 8'h05, 1'b1);
    req_valid = 4'b0100;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h4);
    check("t1_idle_busy", 32'(busy), 32'h0);
    tick();
    req_valid = '0;
    #1;
    check("t1_exec_busy", 32'(busy), 32'h1);
    check("t1_exec_ready", 32'(req_ready), 32'h0);
    check("t1_alu_f", 32'(alu_f), 32'h3);
    check("t1_alu_a", 32'(alu_a), 32'h3C);
    check("t1_alu_b", 32'(alu_b), 32'h05);
    check("t1_alu_cin", 32'(alu_cin), 32'h1);
    check("t1_exec_rv", 32'(resp_valid), 32'h0);
    tick();
    check("t1_resp_valid", 32'(resp_valid), 32'h4);
    check("t1_resp_y", 32'(resp_y), 32'h42);
    check("t1_resp_cout", 32'(resp_cout), 32'h0);
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
    check("t1_done_rv", 32'(resp_valid), 32'h0);
    check("t1_done_busy", 32'(busy), 32'h0);

    // Carry path from requester 0 (pointer is 3, search wraps to 0): FF + 01 = 00, cout 1.
    set_req(0, 2'b00, 8'hFF, 8'h01, 1'b0);
    req_valid = 4'b0001;
    #1;
    check("t2_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    check("t2_resp_valid", 32'(resp_valid), 32'h1);
    check("t2_resp_y", 32'(resp_y), 32'h00);
    check("t2_resp_cout", 32'(resp_cout), 32'h1);
    resp_ready = 4'b0001;
    tick();
    resp_ready = '0;

    // Backpressure on requester 1 while requester 2 waits; non-owner readies ignored.
    set_req(1, 2'b01, 8'h10, 8'h20, 1'b0);
    set_req(2, 2'b10, 8'h01, 8'h02, 1'b1);
    req_valid = 4'b0110;
    #1;
    check("t3_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0100;
    tick();
    resp_ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_rv", 32'(resp_valid), 32'h2);
      check("t3_hold_y", 32'(resp_y), 32'h30);
      check("t3_hold_cout", 32'(resp_cout), 32'h0);
      check("t3_hold_ready", 32'(req_ready), 32'h0);
      tick();
    end
    resp_ready = 4'b0010;
    #1;
    check("t3_release_ready", 32'(req_ready), 32'h0);
    tick();
    resp_ready = '0;
    check("t3_next_ready", 32'(req_ready), 32'h4);
    check("t3_next_rv", 32'(resp_valid), 32'h0);
    tick();
    req_valid = '0;
    tick();
    check("t3_r2_rv", 32'(resp_valid), 32'h4);
    check("t3_r2_y", 32'(resp_y), 32'h04);
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;

    // Asynchronous reset during EXEC; pointer had advanced to 3.
    set_req(2, 2'b01, 8'h55, 8'h11, 1'b0);
    req_valid = 4'b0100;
    tick();
    check("t5_exec_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_ready", 32'(req_ready), 32'h0);
    check("t5_rst_rv", 32'(resp_valid), 32'h0);
    check("t5_rst_alu_a", 32'(alu_a), 32'h0);
    check("t5_rst_alu_b", 32'(alu_b), 32'h0);
    check("t5_rst_alu_f", 32'(alu_f), 32'h0);
    check("t5_rst_resp_y", 32'(resp_y), 32'h0);
    set_req(1, 2'b00, 8'h07, 8'h08, 1'b0);
    set_req(3, 2'b00, 8'h09, 8'h0A, 1'b0);
    req_valid = 4'b1110;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t5_post_rv", 32'(resp_valid), 32'h0);
    check("t5_post_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("t5_exec_rv", 32'(resp_valid), 32'h0);
    tick();
    check("t5_resp_rv", 32'(resp_valid), 32'h2);
    check("t5_resp_y", 32'(resp_y), 32'h0F);
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;

    // All four valid, resp_ready high: grants 0,1,2,3,0, one every 3 cycles.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 8'(16 * i), 8'(i), 1'b0);
    req_valid  = 4'b1111;
    resp_ready = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NREQ;
      check("t4_grant", 32'(req_ready), 32'(1) << g);
      tick();
      check("t4_exec_ready", 32'(req_ready), 32'h0);
      check("t4_exec_alu_a", 32'(alu_a), 32'(16 * g));
      tick();
      check("t4_resp_rv", 32'(resp_valid), 32'(1) << g);
      check("t4_resp_y", 32'(resp_y), 32'(17 * g));
      check("t4_resp_ready", 32'(req_ready), 32'h0);
      tick();
    end
    req_valid  = '0;
    resp_ready = '0;

    // Pointer wrap: pointer is 1, only 3 and 0 valid -> 3 first, then 0.
    set_req(3, 2'b00, 8'h80, 8'h80, 1'b1);
    set_req(0, 2'b00, 8'h12, 8'h34, 1'b0);
    req_valid = 4'b1001;
    #1;
    check("t6_grant3", 32'(req_ready), 32'h8);
    tick();
    tick();
    check("t6_rv3", 32'(resp_valid), 32'h8);
    check("t6_y3", 32'(resp_y), 32'h01);
    check("t6_cout3", 32'(resp_cout), 32'h1);
    resp_ready = 4'b1000;
    tick();
    resp_ready = '0;
    check("t6_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    check("t6_rv0", 32'(resp_valid), 32'h1);
    check("t6_y0", 32'(resp_y), 32'h46);
    resp_ready = 4'b0001;
    tick();
    resp_ready = '0;
    check("t6_idle_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
